// File: rtl/hamming_secc_codec.sv
// Registered Hamming(12,8) SEC codec: independent one-cycle encode and decode
// pipelines plus a saturating count of corrected decodes.
module hamming_secc_codec #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_valid_in,
    input  logic [7:0]       enc_data_in,
    output logic             enc_valid_out,
    output logic [11:0]      enc_code_out,
    input  logic             dec_valid_in,
    input  logic [11:0]      dec_code_in,
    output logic             dec_valid_out,
    output logic [7:0]       dec_data_out,
    output logic [3:0]       dec_syndrome,
    output logic [11:0]      dec_code_fixed,
    output logic             dec_err_corrected,
    output logic             dec_err_invalid,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_cnt_clr
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CODE_W = 12;
    localparam int unsigned SYN_W  = 4;

    // Masks select the codeword bits whose Hamming position has bit N set
    localparam logic [CODE_W-1:0] MASK_C1 = 12'h555;
    localparam logic [CODE_W-1:0] MASK_C2 = 12'h666;
    localparam logic [CODE_W-1:0] MASK_C4 = 12'h878;
    localparam logic [CODE_W-1:0] MASK_C8 = 12'hF80;

    logic [CODE_W-1:0] enc_code_c;
    logic [SYN_W-1:0]  syn_c;
    logic [CODE_W-1:0] flip_c;
    logic [CODE_W-1:0] fixed_c;
    logic [DATA_W-1:0] data_c;
    logic              corr_c;
    logic              inv_c;

    // Encoder: place data at non-power-of-two positions, parity at 1/2/4/8
    always_comb begin
        logic p1, p2, p4, p8;
        p1 = enc_data_in[0] ^ enc_data_in[1] ^ enc_data_in[3] ^ enc_data_in[4] ^ enc_data_in[6];
        p2 = enc_data_in[0] ^ enc_data_in[2] ^ enc_data_in[3] ^ enc_data_in[5] ^ enc_data_in[6];
        p4 = enc_data_in[1] ^ enc_data_in[2] ^ enc_data_in[3] ^ enc_data_in[7];
        p8 = enc_data_in[4] ^ enc_data_in[5] ^ enc_data_in[6] ^ enc_data_in[7];
        enc_code_c = {enc_data_in[7:4], p8, enc_data_in[3:1], p4, enc_data_in[0], p2, p1};
    end

    // Decoder: syndrome, one-hot flip for positions 1..12, data extraction
    always_comb begin
        syn_c  = {^(dec_code_in & MASK_C8), ^(dec_code_in & MASK_C4),
                  ^(dec_code_in & MASK_C2), ^(dec_code_in & MASK_C1)};
        flip_c = '0;
        for (int k = 0; k < int'(CODE_W); k++) begin
            flip_c[k] = (syn_c == SYN_W'(k + 1));
        end
        corr_c  = |flip_c;
        inv_c   = (syn_c > SYN_W'(CODE_W));
        fixed_c = dec_code_in ^ flip_c;
        data_c  = {fixed_c[11:8], fixed_c[6:4], fixed_c[2]};
    end

    // Encode pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_valid_out <= 1'b0;
            enc_code_out  <= '0;
        end else begin
            enc_valid_out <= enc_valid_in;
            if (enc_valid_in) begin
                enc_code_out <= enc_code_c;
            end
        end
    end

    // Decode pipeline register; flags only live alongside dec_valid_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid_out     <= 1'b0;
            dec_data_out      <= '0;
            dec_syndrome      <= '0;
            dec_code_fixed    <= '0;
            dec_err_corrected <= 1'b0;
            dec_err_invalid   <= 1'b0;
        end else begin
            dec_valid_out     <= dec_valid_in;
            dec_err_corrected <= dec_valid_in & corr_c;
            dec_err_invalid   <= dec_valid_in & inv_c;
            if (dec_valid_in) begin
                dec_data_out   <= data_c;
                dec_syndrome   <= syn_c;
                dec_code_fixed <= fixed_c;
            end
        end
    end

    // Saturating corrected-error counter; clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_cnt_clr) begin
            err_cnt <= '0;
        end else if (dec_valid_in && corr_c && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_secc_codec.sv
// Scoreboard bench for hamming_secc_codec: directed vectors plus a full
// byte sweep with every single-bit error; a narrow counter exercises saturation.
module tb_hamming_secc_codec;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             enc_valid_in;
    logic [7:0]       enc_data_in;
    logic             enc_valid_out;
    logic [11:0]      enc_code_out;
    logic             dec_valid_in;
    logic [11:0]      dec_code_in;
    logic             dec_valid_out;
    logic [7:0]       dec_data_out;
    logic [3:0]       dec_syndrome;
    logic [11:0]      dec_code_fixed;
    logic             dec_err_corrected;
    logic             dec_err_invalid;
    logic [CNT_W-1:0] err_cnt;
    logic             err_cnt_clr;

    hamming_secc_codec #(.CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enc_valid_in      (enc_valid_in),
        .enc_data_in       (enc_data_in),
        .enc_valid_out     (enc_valid_out),
        .enc_code_out      (enc_code_out),
        .dec_valid_in      (dec_valid_in),
        .dec_code_in       (dec_code_in),
        .dec_valid_out     (dec_valid_out),
        .dec_data_out      (dec_data_out),
        .dec_syndrome      (dec_syndrome),
        .dec_code_fixed    (dec_code_fixed),
        .dec_err_corrected (dec_err_corrected),
        .dec_err_invalid   (dec_err_invalid),
        .err_cnt           (err_cnt),
        .err_cnt_clr       (err_cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       data;
        logic [3:0]       syn;
        logic [11:0]      fixed;
        logic             corr;
        logic             inv;
        logic [CNT_W-1:0] cnt;
    } dec_exp_t;

    logic [11:0]      enc_q[$];
    dec_exp_t         dec_q[$];
    logic [CNT_W-1:0] m_cnt;
    int               checks;
    int               errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoder built from position indices rather than fixed equations
    function automatic logic [11:0] ref_encode(input logic [7:0] d);
        logic [11:0] cw;
        logic        par;
        int          di;
        cw = '0;
        di = 0;
        for (int k = 1; k <= 12; k++) begin
            if ((k & (k - 1)) != 0) begin
                cw[k-1] = d[di];
                di++;
            end
        end
        for (int p = 1; p <= 8; p = p * 2) begin
            par = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                if (((k & p) != 0) && (k != p)) par = par ^ cw[k-1];
            end
            cw[p-1] = par;
        end
        return cw;
    endfunction

    // Drive one cycle of stimulus at a negedge and record expectations
    task automatic cycle(input logic ev, input logic [7:0] ed, input logic [11:0] ee,
                         input logic dv, input logic [11:0] dc, input dec_exp_t de,
                         input logic clr);
        dec_exp_t e;
        enc_valid_in = ev;
        enc_data_in  = ed;
        dec_valid_in = dv;
        dec_code_in  = dc;
        err_cnt_clr  = clr;
        if (ev) enc_q.push_back(ee);
        if (clr) m_cnt = '0;
        else if (dv && de.corr && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + CNT_W'(1);
        if (dv) begin
            e = de;
            e.cnt = m_cnt;
            dec_q.push_back(e);
        end
        @(negedge clk);
    endtask

    function automatic dec_exp_t mk(input logic [7:0] data, input logic [3:0] syn,
                                    input logic [11:0] fixed, input logic corr, input logic inv);
        dec_exp_t e;
        e.data = data; e.syn = syn; e.fixed = fixed; e.corr = corr; e.inv = inv; e.cnt = '0;
        return e;
    endfunction

    // Monitor: pop and compare whenever an output valid is presented
    always @(negedge clk) begin
        if (enc_valid_out) begin
            if (enc_q.size() == 0) begin
                chk("enc_unexpected_valid", 32'(enc_valid_out), 32'd0);
            end else begin
                chk("enc_code", 32'(enc_code_out), 32'(enc_q.pop_front()));
            end
        end
        if (dec_valid_out) begin
            if (dec_q.size() == 0) begin
                chk("dec_unexpected_valid", 32'(dec_valid_out), 32'd0);
            end else begin
                dec_exp_t e;
                e = dec_q.pop_front();
                chk("dec_data", 32'(dec_data_out), 32'(e.data));
                chk("dec_syndrome", 32'(dec_syndrome), 32'(e.syn));
                chk("dec_code_fixed", 32'(dec_code_fixed), 32'(e.fixed));
                chk("dec_err_corrected", 32'(dec_err_corrected), 32'(e.corr));
                chk("dec_err_invalid", 32'(dec_err_invalid), 32'(e.inv));
                chk("err_cnt", 32'(err_cnt), 32'(e.cnt));
            end
        end
    end

    localparam logic [11:0] CW_AF   = 12'b1010_0111_0101;
    localparam logic [11:0] CW_P1   = 12'b1010_0100_0111;
    localparam logic [11:0] CW_P1OK = 12'b1010_0100_0110;
    localparam logic [11:0] CW_P7   = 12'b1010_0011_0101;
    localparam logic [11:0] CW_INV  = 12'b1010_1111_1100;

    dec_exp_t none;

    initial begin
        checks = 0;
        errors = 0;
        m_cnt  = '0;
        none   = mk(8'h00, 4'h0, 12'h000, 1'b0, 1'b0);

        // Reset held with both request lines active
        rst_n        = 1'b0;
        enc_valid_in = 1'b1;
        enc_data_in  = 8'hAF;
        dec_valid_in = 1'b1;
        dec_code_in  = CW_P1;
        err_cnt_clr  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_enc_valid", 32'(enc_valid_out), 32'd0);
        chk("rst_enc_code", 32'(enc_code_out), 32'd0);
        chk("rst_dec_valid", 32'(dec_valid_out), 32'd0);
        chk("rst_dec_data", 32'(dec_data_out), 32'd0);
        chk("rst_dec_flags", 32'({dec_err_corrected, dec_err_invalid}), 32'd0);
        chk("rst_dec_fixed", 32'(dec_code_fixed), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, 12'h000, 1'b0, 12'h000, none, 1'b0);
        cycle(1'b0, 8'h00, 12'h000, 1'b0, 12'h000, none, 1'b0);
        chk("post_rst_no_enc_valid", 32'(enc_valid_out), 32'd0);
        chk("post_rst_no_dec_valid", 32'(dec_valid_out), 32'd0);

        // Directed vectors
        cycle(1'b1, 8'b1010_1111, CW_AF, 1'b1, CW_P1,
              mk(8'b1010_1001, 4'b0001, CW_P1OK, 1'b1, 1'b0), 1'b0);
        cycle(1'b0, 8'h00, 12'h000, 1'b1, CW_P7,
              mk(8'b1010_1111, 4'b0111, CW_AF, 1'b1, 1'b0), 1'b0);
        cycle(1'b0, 8'h00, 12'h000, 1'b1, CW_INV,
              mk(8'b1010_1111, 4'b1101, CW_INV, 1'b0, 1'b1), 1'b0);
        cycle(1'b0, 8'h00, 12'h000, 1'b0, 12'h000, none, 1'b0);
        chk("idle_enc_valid", 32'(enc_valid_out), 32'd0);
        chk("idle_enc_hold", 32'(enc_code_out), 32'(CW_AF));
        chk("idle_dec_valid", 32'(dec_valid_out), 32'd0);
        chk("idle_flags_clear", 32'({dec_err_corrected, dec_err_invalid}), 32'd0);
        chk("idle_syn_hold", 32'(dec_syndrome), 32'b1101);
        chk("idle_err_cnt", 32'(err_cnt), 32'd2);

        // Counter saturation, then clear beating a simultaneous correction
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 12'h000, 1'b1, CW_P1,
                  mk(8'b1010_1001, 4'b0001, CW_P1OK, 1'b1, 1'b0), 1'b0);
        end
        cycle(1'b0, 8'h00, 12'h000, 1'b1, CW_P1,
              mk(8'b1010_1001, 4'b0001, CW_P1OK, 1'b1, 1'b0), 1'b1);
        cycle(1'b0, 8'h00, 12'h000, 1'b0, 12'h000, none, 1'b0);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);

        // Full sweep: each byte clean (with concurrent encode) and all 12 flips
        for (int b = 0; b < 256; b++) begin
            logic [7:0]  d;
            logic [11:0] cw;
            logic [11:0] bad;
            d  = 8'(b);
            cw = ref_encode(d);
            cycle(1'b1, d, cw, 1'b1, cw, mk(d, 4'h0, cw, 1'b0, 1'b0), 1'b0);
            for (int k = 1; k <= 12; k++) begin
                bad = cw;
                bad[k-1] = ~bad[k-1];
                cycle(1'b0, 8'h00, 12'h000, 1'b1, bad, mk(d, 4'(k), cw, 1'b1, 1'b0), 1'b0);
            end
        end

        // Drain with a bounded wait
        cycle(1'b0, 8'h00, 12'h000, 1'b0, 12'h000, none, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (enc_q.size() == 0 && dec_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_enc_q", 32'(enc_q.size()), 32'd0);
        chk("drain_dec_q", 32'(dec_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
